// File: rtl/adam_pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adam_pwr_seq_pkg
// Description : Shared types for the adam_pwr_seq power/pause sequencer:
//               per-target state encoding, command action encoding, FSM
//               state encoding, and a helper that identifies wait states.
// Revision    : 1.0 - initial release
// ============================================================================
package adam_pwr_seq_pkg;

  typedef enum logic [1:0] {
    TGT_STOPPED = 2'd0,
    TGT_RUNNING = 2'd1,
    TGT_PAUSED  = 2'd2,
    TGT_FAULT   = 2'd3
  } tgt_state_t;

  typedef enum logic [1:0] {
    ACT_NOP    = 2'd0,
    ACT_RESUME = 2'd1,
    ACT_PAUSE  = 2'd2,
    ACT_STOP   = 2'd3
  } cmd_action_t;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_T_SRST_REL    = 3'd1,
    S_T_RESUME_WAIT = 3'd2,
    S_T_PAUSE_WAIT  = 3'd3,
    S_T_SRST_SET    = 3'd4,
    S_G_PAUSE_WAIT  = 3'd5,
    S_G_PAUSED      = 3'd6,
    S_G_RESUME_WAIT = 3'd7
  } fsm_state_t;

  // True for every state that waits on target acknowledges.
  function automatic logic is_wait(input fsm_state_t s);
    return (s == S_T_RESUME_WAIT) || (s == S_T_PAUSE_WAIT) ||
           (s == S_G_PAUSE_WAIT)  || (s == S_G_RESUME_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adam_pwr_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : adam_pwr_seq_timer
// Description : Acknowledge-wait timeout counter. Restarts on i_start, holds
//               at zero while i_clear is high, and flags o_expire during the
//               TIMEOUT_CYCLES-th cycle of a wait.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_start       - restart count (entering a wait state)
//               i_clear       - not waiting; counter held at zero
//               o_expire      - wait limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module adam_pwr_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_start || i_clear) begin
      cnt_d = '0;
    end else if (cnt_q != C_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = !i_clear && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/adam_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : adam_pwr_seq
// Description : Soft-reset and pause/resume sequencer for NO_TGTS targets
//               using the srst / pause_req / pause_ack handshake. Accepts
//               per-target commands and a global upstream pause request.
//               Optional ack-wait timeout enabled by ADAM_PWR_SEQ_TIMEOUT_EN.
// Ports       : clk, rst                  - clock, sync active-high reset
//               pause_req / pause_ack     - global upstream pause handshake
//               cmd_valid / cmd_ready     - command channel handshake
//               cmd_target, cmd_action    - command payload
//               cmd_err                   - pulse: target index out of range
//               busy                      - sequencer not idle
//               tgt_srst, tgt_pause_req   - per-target controls
//               tgt_pause_ack             - per-target acknowledges
//               tgt_state                 - 2 bits per target state
//               timeout_err               - sticky ack-wait timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module adam_pwr_seq
  import adam_pwr_seq_pkg::*;
#(
  parameter int NO_TGTS        = 4,
  parameter int IDX_WIDTH      = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause_req,
  output logic                   pause_ack,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IDX_WIDTH-1:0]   cmd_target,
  input  logic [1:0]             cmd_action,
  output logic                   cmd_err,
  output logic                   busy,
  output logic [NO_TGTS-1:0]     tgt_srst,
  output logic [NO_TGTS-1:0]     tgt_pause_req,
  input  logic [NO_TGTS-1:0]     tgt_pause_ack,
  output logic [2*NO_TGTS-1:0]   tgt_state,
  output logic                   timeout_err
);

  localparam int SW = 2 * NO_TGTS;

  fsm_state_t         state_q, state_d;
  logic [NO_TGTS-1:0] srst_q, srst_d;
  logic [NO_TGTS-1:0] preq_q, preq_d;
  logic [NO_TGTS-1:0] sel_q, sel_d;     // one-hot target of the active command
  logic [NO_TGTS-1:0] mask_q, mask_d;   // targets owned by the global sequence
  logic [SW-1:0]      tstate_q, tstate_d;
  logic               stop_q, stop_d;   // pause is the first half of a STOP
  logic               pack_q, pack_d;
  logic               cerr_q, cerr_d;
  logic               terr_q, terr_d;

  logic [NO_TGTS-1:0] w_cmd_onehot;
  logic [NO_TGTS-1:0] w_running;
  logic [NO_TGTS-1:0] w_off;
  tgt_state_t         w_cmd_state;
  logic               w_idx_ok;
  logic               w_sel_ack;
  logic               w_expire;

  function automatic logic [SW-1:0] set_state(input logic [SW-1:0]      cur,
                                              input logic [NO_TGTS-1:0] m,
                                              input tgt_state_t         s);
    logic [SW-1:0] r;
    r = cur;
    for (int i = 0; i < NO_TGTS; i++) begin
      if (m[i]) r[2*i +: 2] = s;
    end
    return r;
  endfunction

  // Decode the command target one-hot; an index with no matching target is
  // out of range.
  always_comb begin
    w_cmd_onehot = '0;
    w_running    = '0;
    w_cmd_state  = TGT_STOPPED;
    for (int i = 0; i < NO_TGTS; i++) begin
      w_cmd_onehot[i] = (cmd_target == IDX_WIDTH'(i));
      w_running[i]    = (tstate_q[2*i +: 2] == TGT_RUNNING);
      if (w_cmd_onehot[i]) w_cmd_state = tgt_state_t'(tstate_q[2*i +: 2]);
    end
  end

  assign w_idx_ok  = |w_cmd_onehot;
  assign w_sel_ack = |(tgt_pause_ack & sel_q);

  always_comb begin
    state_d  = state_q;
    srst_d   = srst_q;
    preq_d   = preq_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    tstate_d = tstate_q;
    stop_d   = stop_q;
    pack_d   = pack_q;
    cerr_d   = 1'b0;
    terr_d   = terr_q;
    w_off    = '0;

    case (state_q)
      S_IDLE: begin
        // The global pause has priority; a concurrent command stays pending.
        if (pause_req) begin
          mask_d  = w_running;
          preq_d  = preq_q | w_running;
          state_d = S_G_PAUSE_WAIT;
        end else if (cmd_valid) begin
          terr_d = 1'b0;
          if (!w_idx_ok) begin
            cerr_d = 1'b1;
          end else begin
            sel_d  = w_cmd_onehot;
            stop_d = 1'b0;
            case (cmd_action_t'(cmd_action))
              ACT_RESUME: begin
                if (w_cmd_state == TGT_PAUSED) begin
                  preq_d  = preq_q & ~w_cmd_onehot;
                  state_d = S_T_RESUME_WAIT;
                end else if (w_cmd_state != TGT_RUNNING) begin
                  srst_d  = srst_q & ~w_cmd_onehot;
                  state_d = S_T_SRST_REL;
                end
              end
              ACT_PAUSE: begin
                if (w_cmd_state == TGT_RUNNING) begin
                  preq_d  = preq_q | w_cmd_onehot;
                  state_d = S_T_PAUSE_WAIT;
                end
              end
              ACT_STOP: begin
                if (w_cmd_state == TGT_RUNNING) begin
                  preq_d  = preq_q | w_cmd_onehot;
                  stop_d  = 1'b1;
                  state_d = S_T_PAUSE_WAIT;
                end else begin
                  state_d = S_T_SRST_SET;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_T_SRST_REL: begin
        preq_d  = preq_q & ~sel_q;
        state_d = S_T_RESUME_WAIT;
      end

      S_T_RESUME_WAIT: begin
        if (!w_sel_ack) begin
          tstate_d = set_state(tstate_q, sel_q, TGT_RUNNING);
          state_d  = S_IDLE;
        end else if (w_expire) begin
          tstate_d = set_state(tstate_q, sel_q, TGT_FAULT);
          srst_d   = srst_q | sel_q;
          preq_d   = preq_q | sel_q;
          terr_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_T_PAUSE_WAIT: begin
        if (w_sel_ack) begin
          tstate_d = set_state(tstate_q, sel_q, TGT_PAUSED);
          state_d  = stop_q ? S_T_SRST_SET : S_IDLE;
        end else if (w_expire) begin
          tstate_d = set_state(tstate_q, sel_q, TGT_FAULT);
          srst_d   = srst_q | sel_q;
          preq_d   = preq_q | sel_q;
          terr_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_T_SRST_SET: begin
        srst_d   = srst_q | sel_q;
        tstate_d = set_state(tstate_q, sel_q, TGT_STOPPED);
        state_d  = S_IDLE;
      end

      S_G_PAUSE_WAIT: begin
        if (!pause_req) begin
          // Upstream gave up before we acknowledged: unwind without pause_ack.
          preq_d  = preq_q & ~mask_q;
          state_d = S_G_RESUME_WAIT;
        end else if ((tgt_pause_ack & mask_q) == mask_q) begin
          tstate_d = set_state(tstate_q, mask_q, TGT_PAUSED);
          pack_d   = 1'b1;
          state_d  = S_G_PAUSED;
        end else if (w_expire) begin
          w_off    = mask_q & ~tgt_pause_ack;
          tstate_d = set_state(set_state(tstate_q, w_off, TGT_FAULT),
                               mask_q & ~w_off, TGT_PAUSED);
          srst_d   = srst_q | w_off;
          mask_d   = mask_q & ~w_off;
          terr_d   = 1'b1;
          pack_d   = 1'b1;
          state_d  = S_G_PAUSED;
        end
      end

      S_G_PAUSED: begin
        if (!pause_req) begin
          pack_d  = 1'b0;
          preq_d  = preq_q & ~mask_q;
          state_d = S_G_RESUME_WAIT;
        end
      end

      S_G_RESUME_WAIT: begin
        if ((tgt_pause_ack & mask_q) == '0) begin
          tstate_d = set_state(tstate_q, mask_q, TGT_RUNNING);
          state_d  = S_IDLE;
        end else if (w_expire) begin
          w_off    = mask_q & tgt_pause_ack;
          tstate_d = set_state(set_state(tstate_q, w_off, TGT_FAULT),
                               mask_q & ~w_off, TGT_RUNNING);
          srst_d   = srst_q | w_off;
          preq_d   = preq_q | w_off;
          terr_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef ADAM_PWR_SEQ_TIMEOUT_EN
  logic w_tmr_start;
  logic w_tmr_clear;

  // Restart on every entry into a wait state, including wait-to-wait moves.
  assign w_tmr_start = is_wait(state_d) && (state_d != state_q);
  assign w_tmr_clear = !is_wait(state_q);

  adam_pwr_seq_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_tmr_start),
    .i_clear  (w_tmr_clear),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      srst_q   <= '1;
      preq_q   <= '1;
      sel_q    <= '0;
      mask_q   <= '0;
      tstate_q <= '0;
      stop_q   <= 1'b0;
      pack_q   <= 1'b0;
      cerr_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      srst_q   <= srst_d;
      preq_q   <= preq_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      tstate_q <= tstate_d;
      stop_q   <= stop_d;
      pack_q   <= pack_d;
      cerr_q   <= cerr_d;
      terr_q   <= terr_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE) && !pause_req && !rst;
  assign busy          = (state_q != S_IDLE);
  assign pause_ack     = pack_q;
  assign cmd_err       = cerr_q;
  assign timeout_err   = terr_q;
  assign tgt_srst      = srst_q;
  assign tgt_pause_req = preq_q;
  assign tgt_state     = tstate_q;

endmodule
`default_nettype wire

// File: tb/tb_adam_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_adam_pwr_seq
// Description : Directed self-checking bench for adam_pwr_seq (4 targets,
//               3-bit command index so out-of-range indices can be issued).
//               Targets are modelled as acknowledging their pause request
//               just after each clock edge, unless held low by ack_lo.
//               Timeout steps run when ADAM_PWR_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adam_pwr_seq;

  localparam int NO_TGTS = 4;
  localparam int IDX_W   = 3;

  logic             clk;
  logic             rst;
  logic             pause_req;
  logic             pause_ack;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_target;
  logic [1:0]       cmd_action;
  logic             cmd_err;
  logic             busy;
  logic [3:0]       tgt_srst;
  logic [3:0]       tgt_pause_req;
  logic [3:0]       tgt_pause_ack;
  logic [7:0]       tgt_state;
  logic             timeout_err;
  logic [3:0]       ack_lo;

  int n_checks = 0;
  int n_err    = 0;

  adam_pwr_seq #(
    .NO_TGTS        (NO_TGTS),
    .IDX_WIDTH      (IDX_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pause_req     (pause_req),
    .pause_ack     (pause_ack),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_action    (cmd_action),
    .cmd_err       (cmd_err),
    .busy          (busy),
    .tgt_srst      (tgt_srst),
    .tgt_pause_req (tgt_pause_req),
    .tgt_pause_ack (tgt_pause_ack),
    .tgt_state     (tgt_state),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; targets answer their pause request after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tgt_pause_ack = tgt_pause_req & ~ack_lo;
    end
  endtask

  // Present a command, confirm it is acceptable, and let one edge accept it.
  task automatic send(input logic [IDX_W-1:0] t, input logic [1:0] a);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_action = a;
    #1;
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    pause_req     = 1'b0;
    cmd_valid     = 1'b0;
    cmd_target    = '0;
    cmd_action    = 2'd0;
    ack_lo        = 4'h0;
    tgt_pause_ack = 4'hF;

    // Reset
    tick(3);
    check("ready_in_rst", cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_srst",   tgt_srst, 4'hF);
    check("rst_preq",   tgt_pause_req, 4'hF);
    check("rst_state",  tgt_state, 8'h00);
    check("rst_ready",  cmd_ready, 1'b1);
    check("rst_busy",   busy, 1'b0);
    check("rst_pack",   pause_ack, 1'b0);
    check("rst_cerr",   cmd_err, 1'b0);
    check("rst_terr",   timeout_err, 1'b0);

    // RESUME target 3 from STOPPED
    send(3'd3, 2'd1);
    check("res3_srst_rel", tgt_srst, 4'h7);
    check("res3_busy",     busy, 1'b1);
    tick(2);
    check("res3_state", tgt_state, 8'h40);
    check("res3_preq",  tgt_pause_req, 4'h7);
    check("res3_idle",  busy, 1'b0);

    // RESUME 0 and 1, then PAUSE 1
    send(3'd0, 2'd1);
    tick(2);
    send(3'd1, 2'd1);
    tick(2);
    check("res01_state", tgt_state, 8'h45);
    check("res01_srst",  tgt_srst, 4'h4);
    send(3'd1, 2'd2);
    tick(1);
    check("pause1_state", tgt_state, 8'h49);
    check("pause1_preq",  tgt_pause_req, 4'h6);

    // Global pause raised together with a pending PAUSE 0 command
    cmd_valid  = 1'b1;
    cmd_target = 3'd0;
    cmd_action = 2'd2;
    pause_req  = 1'b1;
    #1;
    check("gp_ready_blocked", cmd_ready, 1'b0);
    tick(1);
    check("gp_preq_mask", tgt_pause_req, 4'hF);
    check("gp_pack_wait", pause_ack, 1'b0);
    tick(1);
    check("gp_pack",   pause_ack, 1'b1);
    check("gp_state",  tgt_state, 8'h8A);
    pause_req = 1'b0;
    tick(1);
    check("gr_pack_drop", pause_ack, 1'b0);
    check("gr_preq",      tgt_pause_req, 4'h6);
    tick(1);
    check("gr_state", tgt_state, 8'h49);
    check("gr_ready", cmd_ready, 1'b1);
    tick(1);
    cmd_valid = 1'b0;
    check("pend_preq", tgt_pause_req, 4'h7);
    tick(1);
    check("pend_state", tgt_state, 8'h4A);
    send(3'd0, 2'd1);
    tick(1);
    check("res0_from_paused", tgt_state, 8'h49);

    // Global pause abandoned while target 0 withholds its ack
    ack_lo    = 4'h1;
    pause_req = 1'b1;
    tick(3);
    check("gab_pack", pause_ack, 1'b0);
    check("gab_busy", busy, 1'b1);
    pause_req = 1'b0;
    tick(1);
    check("gab_pack2", pause_ack, 1'b0);
    tick(1);
    check("gab_state", tgt_state, 8'h49);
    check("gab_preq",  tgt_pause_req, 4'h6);
    check("gab_idle",  busy, 1'b0);
    ack_lo = 4'h0;

    // Out-of-range target index
    send(3'd5, 2'd3);
    check("inv_cerr",  cmd_err, 1'b1);
    check("inv_state", tgt_state, 8'h49);
    check("inv_busy",  busy, 1'b0);
    tick(1);
    check("inv_cerr_pulse", cmd_err, 1'b0);

    // STOP a RUNNING target 2
    send(3'd2, 2'd1);
    tick(2);
    check("res2_state", tgt_state, 8'h59);
    send(3'd2, 2'd3);
    check("stop_preq", tgt_pause_req, 4'h6);
    tick(1);
    check("stop_paused", tgt_state, 8'h69);
    check("stop_srst_hold", tgt_srst, 4'h0);
    tick(1);
    check("stop_srst",  tgt_srst, 4'h4);
    check("stop_state", tgt_state, 8'h49);
    check("stop_idle",  busy, 1'b0);

    // NOP
    send(3'd1, 2'd0);
    check("nop_state", tgt_state, 8'h49);
    check("nop_busy",  busy, 1'b0);

`ifdef ADAM_PWR_SEQ_TIMEOUT_EN
    // PAUSE target 0 whose ack never rises
    ack_lo = 4'h1;
    send(3'd0, 2'd2);
    tick(15);
    check("to_wait_busy", busy, 1'b1);
    check("to_wait_terr", timeout_err, 1'b0);
    tick(1);
    check("to_state", tgt_state, 8'h4B);
    check("to_terr",  timeout_err, 1'b1);
    check("to_ready", cmd_ready, 1'b1);
    check("to_srst",  tgt_srst, 4'h5);
    check("to_preq",  tgt_pause_req, 4'h7);
    ack_lo = 4'h0;
    send(3'd1, 2'd0);
    check("to_terr_clr", timeout_err, 1'b0);
`else
    check("no_timeout_flag", timeout_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
